ecc_ladder_seq: RTL and testbench
=================================

// Module: ecc_ladder_seq
// PURPOSE
//  Parametrised Montgomery-ladder sequencer for GF(2^m) scalar multiplication; successor to the fixed-163-bit ladder FSM.
//  Latches scalar k at start, skips leading zeros, then issues one micro-op per step (ADD/SQR/MUL) to the field datapath
//  and register file, with a conditional swap per key bit. Adds zero-scalar detect, abort, busy and bit-index reporting.
// PARAMETERS
//  K_W      163               scalar width in bits (>=2)
//  CNT_W    $clog2(K_W)       bit-index counter width
//  SKIP_LZ  1                 1: scan past leading zeros; 0: start ladder at bit K_W-1 (top bit treated as the leading 1)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      async active-low reset
//  start      in   1      1-cycle request; accepted only while busy=0
//  abort      in   1      synchronous abort, any state
//  k          in   K_W    scalar; sampled into k_reg on accepted start
//  m_done     in   1      multiplier completion pulse for the current MUL op
//  op_valid   out  1      1-cycle strobe: micro-op fields valid
//  op_code    out  2      0 NOP, 1 ADD, 2 SQR, 3 MUL
//  op_src_a   out  3      register id: 0 X, 1 X1, 2 X2, 3 Z1, 4 Z2, 5 Z3
//  op_src_b   out  3      second source (ADD/MUL); 0 for SQR
//  op_dst     out  3      destination register id
//  cswap      out  1      1-cycle strobe: conditional swap (X1,Z1)<->(X2,Z2)
//  cswap_bit  out  1      current key bit ki; datapath swaps when 1
//  bit_idx    out  CNT_W  index of the bit being processed
//  busy       out  1      high from accepted start until done/abort
//  ecc_done   out  1      1-cycle completion pulse
//  k_zero     out  1      valid with ecc_done: k_reg was all-zero (result = point at infinity)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; k_reg, counter 0.
//  - Datapath contract: ADD/SQR complete in the op_valid cycle; MUL completes at m_done, any number of cycles later (>=1).
//  - States: IDLE -> SCAN -> INIT -> (SWAP -> LADDER -> UNSWAP)* -> DONE -> IDLE.
//  - IDLE: start=1 & abort=0 -> latch k, bit_idx=K_W-1, busy=1; go SCAN (or INIT if SKIP_LZ=0).
//  - SCAN: one bit/cycle. k_reg[bit_idx]=1 -> INIT. Bit 0 tested and is 0 -> DONE with k_zero=1 (no ops issued).
//  - INIT ops, in order, one per cycle: X1=X (ADD X+0 via src_b=X? no: encoded ADD src_a=X,src_b=X,dst=X1 is illegal;
//    use SQR-free copy op: op_code=ADD, src_a=X, src_b=0, dst=X1, where src_b=0 means constant zero), Z2=SQR X1,
//    X2=SQR Z2, X2=ADD X2,Z1. Z1 is preset to 1 by the datapath on accepted start.
//  - After INIT: if bit_idx=0 -> DONE; else bit_idx-=1, go SWAP.
//  - SWAP: cswap=1, cswap_bit=k_reg[bit_idx], one cycle.
//  - LADDER op list (MUL ops hold state, op_valid only on first cycle, advance on m_done):
//    MUL X1=X1*Z2; MUL Z1=Z1*X2; SQR X2; SQR Z3=Z2; MUL Z2=Z3*X2; ADD X2=X2+Z3; SQR X2;
//    MUL Z3=X1*Z1; ADD Z1=X1+Z1; SQR Z1; MUL X1=Z1*X; ADD X1=X1+Z3.
//  - UNSWAP: cswap=1 with same cswap_bit; then bit_idx=0 -> DONE, else bit_idx-=1 -> SWAP.
//  - DONE: ecc_done=1 one cycle, busy=0 next cycle; k_zero=1 only on the zero-scalar path.
//  - m_done outside a MUL wait is ignored. start while busy ignored; k changes after start have no effect.
//  - abort: next cycle IDLE, busy=0, op_valid=cswap=0, no ecc_done; an in-flight MUL result is discarded.
//    abort with start in the same IDLE cycle: abort wins.
//  - Async reset mid-operation: immediate return to reset values.
// TESTING
//  - K_W=8, k=8'h00: start -> 8 SCAN cycles, ecc_done=1 with k_zero=1, zero op_valid strobes.
//  - K_W=8, k=8'h01: leading 1 at bit 0 -> 4 INIT ops then ecc_done, no cswap, k_zero=0.
//  - K_W=8, k=8'h05, m_done 3 cycles after each MUL: 2 ladder bits, cswap_bit 0 then 1, 24 ladder ops total, 5 MULs/bit.
//  - K_W=163, random k vs. software ladder model driving a field datapath: final X1/Z1 match reference point.
//  - abort during a MUL wait, then start with k=8'h03 -> clean restart, no stray ecc_done.
//  - start pulsed while busy, and spurious m_done during SQR -> op sequence unchanged.

Source files
------------

// File: rtl/ecc_ladder_seq.sv
// ---------------------------------------------------------------------------
// ecc_ladder_seq
//   Montgomery-ladder sequencer for GF(2^m) scalar multiplication.
//   Latches the scalar k on an accepted start and optionally scans past the
//   leading zeros. It then issues the INIT micro-ops, followed by one
//   SWAP / LADDER / UNSWAP round for every remaining key bit. Each round
//   issues 12 micro-ops (ADD/SQR/MUL) to an external field datapath and
//   register file, and brackets them with a conditional swap.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        1-cycle request, accepted only while busy=0
//   abort        synchronous abort, wins over everything (including start)
//   k            scalar, sampled on an accepted start
//   m_done       multiplier completion for the outstanding MUL
//   op_valid     1-cycle strobe qualifying op_code/op_src_a/op_src_b/op_dst
//   op_code      0 NOP, 1 ADD, 2 SQR, 3 MUL
//   op_src_a/b   register ids 0 X, 1 X1, 2 X2, 3 Z1, 4 Z2, 5 Z3
//   op_dst       destination register id
//   cswap        1-cycle strobe: conditional swap (X1,Z1)<->(X2,Z2)
//   cswap_bit    key bit that controls the swap (held between strobes)
//   bit_idx      index of the key bit being processed
//   busy         high from accepted start until completion/abort
//   ecc_done     1-cycle completion pulse
//   k_zero       valid with ecc_done: the scalar was all-zero
//
// Register-id 0 in src_b has two meanings. For ADD it is the constant zero,
// which makes ADD usable as a plain copy. For MUL it is the base coordinate X.
// ---------------------------------------------------------------------------
module ecc_ladder_seq #(
  parameter int K_W     = 163,
  parameter int CNT_W   = $clog2(K_W),
  parameter bit SKIP_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [K_W-1:0]   k,
  input  logic             m_done,
  output logic             op_valid,
  output logic [1:0]       op_code,
  output logic [2:0]       op_src_a,
  output logic [2:0]       op_src_b,
  output logic [2:0]       op_dst,
  output logic             cswap,
  output logic             cswap_bit,
  output logic [CNT_W-1:0] bit_idx,
  output logic             busy,
  output logic             ecc_done,
  output logic             k_zero
);

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SQR = 2'd2;
  localparam logic [1:0] OP_MUL = 2'd3;

  localparam logic [2:0] R_X  = 3'd0;
  localparam logic [2:0] R_X1 = 3'd1;
  localparam logic [2:0] R_X2 = 3'd2;
  localparam logic [2:0] R_Z1 = 3'd3;
  localparam logic [2:0] R_Z2 = 3'd4;
  localparam logic [2:0] R_Z3 = 3'd5;
  localparam logic [2:0] R_NONE = 3'd0;

  localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(K_W - 1);
  localparam logic [CNT_W-1:0] IDX_ONE = CNT_W'(1);
  localparam logic [3:0]       INIT_LAST   = 4'd3;
  localparam logic [3:0]       LADDER_LAST = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_INIT   = 3'd2,
    S_SWAP   = 3'd3,
    S_LADDER = 3'd4,
    S_UNSWAP = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Micro-op word layout: {code[1:0], src_a[2:0], src_b[2:0], dst[2:0]}.
  function automatic logic [10:0] init_op(input logic [3:0] s);
    logic [10:0] w;
    case (s)
      4'd0:    w = {OP_ADD, R_X,  R_NONE, R_X1};  // X1 = X (copy via +0)
      4'd1:    w = {OP_SQR, R_X1, R_NONE, R_Z2};  // Z2 = X1^2
      4'd2:    w = {OP_SQR, R_Z2, R_NONE, R_X2};  // X2 = Z2^2
      4'd3:    w = {OP_ADD, R_X2, R_Z1,   R_X2};  // X2 = X2 + Z1
      default: w = {OP_NOP, R_NONE, R_NONE, R_NONE};
    endcase
    return w;
  endfunction

  function automatic logic [10:0] ladder_op(input logic [3:0] s);
    logic [10:0] w;
    case (s)
      4'd0:    w = {OP_MUL, R_X1, R_Z2,   R_X1};  // X1 = X1*Z2
      4'd1:    w = {OP_MUL, R_Z1, R_X2,   R_Z1};  // Z1 = Z1*X2
      4'd2:    w = {OP_SQR, R_X2, R_NONE, R_X2};  // X2 = X2^2
      4'd3:    w = {OP_SQR, R_Z2, R_NONE, R_Z3};  // Z3 = Z2^2
      4'd4:    w = {OP_MUL, R_Z3, R_X2,   R_Z2};  // Z2 = Z3*X2
      4'd5:    w = {OP_ADD, R_X2, R_Z3,   R_X2};  // X2 = X2 + Z3
      4'd6:    w = {OP_SQR, R_X2, R_NONE, R_X2};  // X2 = X2^2
      4'd7:    w = {OP_MUL, R_X1, R_Z1,   R_Z3};  // Z3 = X1*Z1
      4'd8:    w = {OP_ADD, R_X1, R_Z1,   R_Z1};  // Z1 = X1 + Z1
      4'd9:    w = {OP_SQR, R_Z1, R_NONE, R_Z1};  // Z1 = Z1^2
      4'd10:   w = {OP_MUL, R_Z1, R_X,    R_X1};  // X1 = Z1*X
      4'd11:   w = {OP_ADD, R_X1, R_Z3,   R_X1};  // X1 = X1 + Z3
      default: w = {OP_NOP, R_NONE, R_NONE, R_NONE};
    endcase
    return w;
  endfunction

  state_t           state;
  logic [K_W-1:0]   k_reg;
  logic [3:0]       step;      // op index inside INIT/LADDER, phase inside DONE
  logic             mul_wait;  // a MUL has been issued and awaits m_done
  logic             zero_r;    // scan ran off bit 0 without finding a 1
  logic [10:0]      cur_op_s;
  logic             cur_is_mul_s;

  // Select the micro-op word for the current step.
  always_comb begin
    cur_op_s = {OP_NOP, R_NONE, R_NONE, R_NONE};
    if (state == S_INIT) begin
      cur_op_s = init_op(step);
    end else begin
      cur_op_s = ladder_op(step);
    end
    cur_is_mul_s = (cur_op_s[10:9] == OP_MUL);
  end

  // Sequencer FSM with registered micro-op, swap and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k_reg     <= '0;
      step      <= 4'd0;
      mul_wait  <= 1'b0;
      zero_r    <= 1'b0;
      op_valid  <= 1'b0;
      op_code   <= OP_NOP;
      op_src_a  <= R_NONE;
      op_src_b  <= R_NONE;
      op_dst    <= R_NONE;
      cswap     <= 1'b0;
      cswap_bit <= 1'b0;
      bit_idx   <= '0;
      busy      <= 1'b0;
      ecc_done  <= 1'b0;
      k_zero    <= 1'b0;
    end else begin
      // Strobes are single-cycle; fields read as NOP when not valid.
      op_valid <= 1'b0;
      op_code  <= OP_NOP;
      op_src_a <= R_NONE;
      op_src_b <= R_NONE;
      op_dst   <= R_NONE;
      cswap    <= 1'b0;
      ecc_done <= 1'b0;
      k_zero   <= 1'b0;

      if (abort) begin
        // Any outstanding MUL result is dropped because mul_wait is cleared.
        state    <= S_IDLE;
        step     <= 4'd0;
        mul_wait <= 1'b0;
        zero_r   <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              k_reg    <= k;
              bit_idx  <= TOP_IDX;
              busy     <= 1'b1;
              zero_r   <= 1'b0;
              step     <= 4'd0;
              mul_wait <= 1'b0;
              state    <= SKIP_LZ ? S_SCAN : S_INIT;
            end
          end

          S_SCAN: begin
            if (k_reg[bit_idx]) begin
              state <= S_INIT;
              step  <= 4'd0;
            end else if (bit_idx == '0) begin
              zero_r <= 1'b1;
              state  <= S_DONE;
              step   <= 4'd0;
            end else begin
              bit_idx <= bit_idx - IDX_ONE;
            end
          end

          S_INIT: begin
            op_valid <= 1'b1;
            {op_code, op_src_a, op_src_b, op_dst} <= cur_op_s;
            if (step == INIT_LAST) begin
              step <= 4'd0;
              if (bit_idx == '0) begin
                state <= S_DONE;
              end else begin
                bit_idx <= bit_idx - IDX_ONE;
                state   <= S_SWAP;
              end
            end else begin
              step <= step + 4'd1;
            end
          end

          S_SWAP: begin
            cswap     <= 1'b1;
            cswap_bit <= k_reg[bit_idx];
            step      <= 4'd0;
            state     <= S_LADDER;
          end

          S_LADDER: begin
            if (!mul_wait) begin
              op_valid <= 1'b1;
              {op_code, op_src_a, op_src_b, op_dst} <= cur_op_s;
              if (cur_is_mul_s) begin
                mul_wait <= 1'b1;
              end else if (step == LADDER_LAST) begin
                step  <= 4'd0;
                state <= S_UNSWAP;
              end else begin
                step <= step + 4'd1;
              end
            end else if (m_done && !op_valid) begin
              // A completion in the issue cycle itself is not a valid
              // response; the multiplier needs at least one cycle.
              mul_wait <= 1'b0;
              if (step == LADDER_LAST) begin
                step  <= 4'd0;
                state <= S_UNSWAP;
              end else begin
                step <= step + 4'd1;
              end
            end
          end

          S_UNSWAP: begin
            cswap <= 1'b1;
            step  <= 4'd0;
            if (bit_idx == '0) begin
              state <= S_DONE;
            end else begin
              bit_idx <= bit_idx - IDX_ONE;
              state   <= S_SWAP;
            end
          end

          S_DONE: begin
            // Phase 0 raises ecc_done; phase 1 drops busy one cycle later.
            if (step == 4'd0) begin
              ecc_done <= 1'b1;
              k_zero   <= zero_r;
              step     <= 4'd1;
            end else begin
              busy  <= 1'b0;
              step  <= 4'd0;
              state <= S_IDLE;
            end
          end

          default: begin
            state    <= S_IDLE;
            step     <= 4'd0;
            mul_wait <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ecc_ladder_seq.sv
// ---------------------------------------------------------------------------
// tb_ecc_ladder_seq
//   Bench for ecc_ladder_seq with K_W=8. A reference model derives the
//   expected stream of micro-ops and swaps directly from the ladder
//   algorithm: find the leading one, run INIT, then perform one round per
//   lower key bit. The bench checks the DUT stream against that model,
//   together with the completion flags, abort handling and async reset.
// ---------------------------------------------------------------------------
module tb_ecc_ladder_seq;

  localparam int K_W   = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [K_W-1:0]   k = '0;
  logic             m_done = 1'b0;
  logic             op_valid;
  logic [1:0]       op_code;
  logic [2:0]       op_src_a;
  logic [2:0]       op_src_b;
  logic [2:0]       op_dst;
  logic             cswap;
  logic             cswap_bit;
  logic [CNT_W-1:0] bit_idx;
  logic             busy;
  logic             ecc_done;
  logic             k_zero;

  ecc_ladder_seq #(.K_W(K_W), .CNT_W(CNT_W), .SKIP_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .k(k),
    .m_done(m_done), .op_valid(op_valid), .op_code(op_code),
    .op_src_a(op_src_a), .op_src_b(op_src_b), .op_dst(op_dst),
    .cswap(cswap), .cswap_bit(cswap_bit), .bit_idx(bit_idx), .busy(busy),
    .ecc_done(ecc_done), .k_zero(k_zero)
  );

  always #5 clk = ~clk;

  // kind: 1 micro-op, 2 swap before a round, 3 swap after a round.
  typedef struct packed {
    logic [1:0]  kind;
    logic [10:0] op;
    logic        csb;
    logic [2:0]  idx;
  } ev_t;

  int          errors = 0;
  int          checks = 0;
  ev_t         exp_q[$];
  logic        exp_zero;
  int          exp_ops;
  int          exp_muls;
  logic [10:0] init_tab [4];
  logic [10:0] lad_tab  [12];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [10:0] mk(input int c, input int a, input int b, input int d);
    logic [1:0] c2 = c[1:0];
    logic [2:0] a3 = a[2:0];
    logic [2:0] b3 = b[2:0];
    logic [2:0] d3 = d[2:0];
    return {c2, a3, b3, d3};
  endfunction

  // Reference model: the expected event stream for scalar kv.
  function automatic void build(input logic [7:0] kv);
    int p = -1;
    exp_q.delete();
    for (int i = 0; i < K_W; i++) if (kv[i]) p = i;
    exp_zero = (p < 0);
    exp_ops  = (p < 0) ? 0 : 4 + 12 * p;
    exp_muls = (p < 0) ? 0 : 5 * p;
    if (p >= 0) begin
      for (int j = 0; j < 4; j++) exp_q.push_back('{2'd1, init_tab[j], 1'b0, 3'd0});
      for (int i = p - 1; i >= 0; i--) begin
        exp_q.push_back('{2'd2, 11'd0, kv[i], 3'(i)});
        for (int j = 0; j < 12; j++) exp_q.push_back('{2'd1, lad_tab[j], 1'b0, 3'd0});
        exp_q.push_back('{2'd3, 11'd0, kv[i], 3'd0});
      end
    end
  endfunction

  function automatic ev_t pop_exp();
    ev_t e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  // One full operation; mdel=0 picks random MUL latencies 1..4.
  task automatic run(input logic [7:0] kv, input int mdel, input bit noise);
    int   mcnt = 0;
    int   nops = 0;
    int   nmul = 0;
    bit   done = 0;
    bit   last_nonmul = 0;
    ev_t  e, o;
    build(kv);
    @(negedge clk);
    k = kv;
    start = 1'b1;
    for (int guard = 0; guard < 4000 && !done; guard++) begin
      @(negedge clk);
      start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (noise) k = 8'($urandom);
      m_done = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) m_done = 1'b1;
      end else if (noise && last_nonmul && $urandom_range(0, 1) == 1) begin
        m_done = 1'b1;
      end
      last_nonmul = 0;
      if (guard == 0) chk("busy_on", 32'(busy), 32'd1);
      if (op_valid) begin
        o = '{2'd1, {op_code, op_src_a, op_src_b, op_dst}, 1'b0, 3'd0};
        e = pop_exp();
        chk("op", 32'(o), 32'(e));
        nops++;
        if (op_code == 2'd3) begin
          nmul++;
          mcnt = (mdel > 0) ? mdel : $urandom_range(1, 4);
        end else begin
          last_nonmul = 1;
        end
      end
      if (cswap) begin
        e = pop_exp();
        if (e.kind == 2'd3) o = '{2'd3, 11'd0, cswap_bit, 3'd0};
        else                o = '{2'd2, 11'd0, cswap_bit, bit_idx};
        chk("cswap", 32'(o), 32'(e));
      end
      if (ecc_done) begin
        done = 1;
        chk("k_zero", 32'(k_zero), 32'(exp_zero));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("op_count", 32'(nops), 32'(exp_ops));
        chk("mul_count", 32'(nmul), 32'(exp_muls));
      end
    end
    chk("done_seen", 32'(done), 32'd1);
    start = 1'b0;
    m_done = 1'b0;
    @(negedge clk);
    chk("busy_off", 32'(busy), 32'd0);
  endtask

  initial begin
    bit found;
    init_tab[0] = mk(1, 0, 0, 1);
    init_tab[1] = mk(2, 1, 0, 4);
    init_tab[2] = mk(2, 4, 0, 2);
    init_tab[3] = mk(1, 2, 3, 2);
    lad_tab[0]  = mk(3, 1, 4, 1);
    lad_tab[1]  = mk(3, 3, 2, 3);
    lad_tab[2]  = mk(2, 2, 0, 2);
    lad_tab[3]  = mk(2, 4, 0, 5);
    lad_tab[4]  = mk(3, 5, 2, 4);
    lad_tab[5]  = mk(1, 2, 5, 2);
    lad_tab[6]  = mk(2, 2, 0, 2);
    lad_tab[7]  = mk(3, 1, 3, 5);
    lad_tab[8]  = mk(1, 1, 3, 3);
    lad_tab[9]  = mk(2, 3, 0, 3);
    lad_tab[10] = mk(3, 3, 0, 1);
    lad_tab[11] = mk(1, 1, 5, 1);

    // Reset values.
    #12;
    chk("reset_outs", 32'({op_valid, op_code, op_src_a, op_src_b, op_dst, cswap,
                           cswap_bit, bit_idx, busy, ecc_done, k_zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scalars: zero, leading one at bit 0, two ladder bits.
    run(8'h00, 0, 1'b0);
    run(8'h01, 0, 1'b0);
    run(8'h05, 3, 1'b0);
    run(8'h80, 1, 1'b1);
    run(8'hFF, 0, 1'b1);

    // Abort during a MUL wait, stale m_done afterwards, then clean restart.
    @(negedge clk);
    k = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (op_valid && op_code == 2'd3) found = 1;
    end
    chk("mul_reached", 32'(found), 32'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_state", 32'({busy, op_valid, cswap, ecc_done}), 32'd0);
    m_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m_done = 1'b0;
      chk("abort_quiet", 32'({busy, op_valid, cswap, ecc_done}), 32'd0);
    end
    run(8'h03, 2, 1'b0);

    // Abort and start in the same idle cycle: abort wins.
    @(negedge clk);
    k = 8'h01;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins", 32'({busy, op_valid}), 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_wins_idle", 32'({busy, op_valid, ecc_done}), 32'd0);

    // Async reset in the middle of a ladder.
    @(negedge clk);
    k = 8'h80;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({op_valid, op_code, cswap, cswap_bit, bit_idx, busy,
                            ecc_done, k_zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(8'h06, 0, 1'b0);

    // Random scalars with noise on start, k and m_done.
    for (int i = 0; i < 8; i++) run(8'($urandom), 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
